cam_seq_ctrl: RTL and testbench

//  Top-level sequencer for the digital-camera pixel array. Holds the exposure

---
 rtl/cam_pkg.sv | 29 ++
 rtl/cam_exp_reg.sv | 47 ++++
 rtl/cam_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_cam_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and default constants for the camera capture sequencer.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPOSE = 2'd1,
        READ1  = 2'd2,
        READ2  = 2'd3
    } cam_state_t;

    localparam int EXP_MIN_DEF     = 2;
    localparam int EXP_MAX_DEF     = 30;
    localparam int EXP_DEFAULT_DEF = 2;
    localparam int TICK_DIV_DEF    = 1;
    localparam int ADC_CYC_DEF     = 2;
    localparam int EXP_W_DEF       = 5;

    // One quiet guard cycle before and after the ADC strobe in each row window.
    localparam int RD_GUARD        = 2;

    // Phase counter width; wide enough for EXP_MAX*TICK_DIV with headroom.
    localparam int CNT_W           = 16;

    // Length of one row readout window in clk cycles.
    function automatic int rd_len(input int adc_cyc);
        return adc_cyc + RD_GUARD;
    endfunction

endpackage

// File: rtl/cam_exp_reg.sv
// Saturating exposure-time register, stepped by the user inc/dec buttons.
module cam_exp_reg
    import cam_pkg::*;
#(
    parameter int EXP_MIN     = EXP_MIN_DEF,
    parameter int EXP_MAX     = EXP_MAX_DEF,
    parameter int EXP_DEFAULT = EXP_DEFAULT_DEF,
    parameter int EXP_W       = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    output logic [EXP_W-1:0] exp_time
);

    logic [EXP_W-1:0] exp_time_q;
    logic [EXP_W-1:0] exp_time_d;

    // Step the setting by one, clamping at the limits; simultaneous inc/dec holds.
    always_comb begin
        exp_time_d = exp_time_q;
        if (en && inc && !dec) begin
            if (exp_time_q >= EXP_W'(EXP_MAX))
                exp_time_d = EXP_W'(EXP_MAX);
            else
                exp_time_d = exp_time_q + EXP_W'(1);
        end else if (en && dec && !inc) begin
            if (exp_time_q <= EXP_W'(EXP_MIN))
                exp_time_d = EXP_W'(EXP_MIN);
            else
                exp_time_d = exp_time_q - EXP_W'(1);
        end
    end

    // Setting register with synchronous return to the power-up default.
    always_ff @(posedge clk) begin
        if (reset)
            exp_time_q <= EXP_W'(EXP_DEFAULT);
        else
            exp_time_q <= exp_time_d;
    end

    assign exp_time = exp_time_q;

endmodule

// File: rtl/cam_seq_ctrl.sv
// Camera capture sequencer: erase -> expose -> row-1 readout -> row-2 readout.
// Optional frame counter output enabled by defining CAM_FRAME_CNT_EN.
module cam_seq_ctrl
    import cam_pkg::*;
#(
    parameter int EXP_MIN     = EXP_MIN_DEF,
    parameter int EXP_MAX     = EXP_MAX_DEF,
    parameter int EXP_DEFAULT = EXP_DEFAULT_DEF,
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int ADC_CYC     = ADC_CYC_DEF,
    parameter int EXP_W       = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             exp_inc,
    input  logic             exp_dec,
    output logic [EXP_W-1:0] exp_time,
    output logic             erase,
    output logic             expose,
    output logic             nre_1,
    output logic             nre_2,
    output logic             adc,
    output logic             busy
`ifdef CAM_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int               RD_LEN  = rd_len(ADC_CYC);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LEN - 1);
    localparam logic [CNT_W-1:0] ADC_LO  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADC_HI  = CNT_W'(ADC_CYC);

    cam_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] exp_len_q, exp_len_d;

    logic erase_q, erase_d;
    logic expose_q, expose_d;
    logic nre_1_q, nre_1_d;
    logic nre_2_q, nre_2_d;
    logic adc_q, adc_d;
    logic busy_q, busy_d;

    // The exposure setting may only move while idle and not launching a capture.
    cam_exp_reg #(
        .EXP_MIN     (EXP_MIN),
        .EXP_MAX     (EXP_MAX),
        .EXP_DEFAULT (EXP_DEFAULT),
        .EXP_W       (EXP_W)
    ) u_exp_reg (
        .clk      (clk),
        .reset    (reset),
        .en       ((state_q == IDLE) && !init),
        .inc      (exp_inc),
        .dec      (exp_dec),
        .exp_time (exp_time)
    );

    // Next state and in-state cycle counter; exposure length is frozen on entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exp_len_d = exp_len_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (init) begin
                    state_d   = EXPOSE;
                    exp_len_d = CNT_W'(exp_time) * CNT_W'(TICK_DIV);
                end
            end
            EXPOSE: begin
                if (cnt_q == exp_len_q - CNT_W'(1)) begin
                    state_d = READ1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            READ1: begin
                if (cnt_q == RD_LAST) begin
                    state_d = READ2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            READ2: begin
                if (cnt_q == RD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Decode outputs from the upcoming state so they can be registered in step with it.
    always_comb begin
        erase_d  = 1'b0;
        expose_d = 1'b0;
        nre_1_d  = 1'b1;
        nre_2_d  = 1'b1;
        adc_d    = 1'b0;
        busy_d   = 1'b1;
        case (state_d)
            IDLE: begin
                erase_d = 1'b1;
                busy_d  = 1'b0;
            end
            EXPOSE: expose_d = 1'b1;
            READ1: begin
                nre_1_d = 1'b0;
                adc_d   = (cnt_d >= ADC_LO) && (cnt_d <= ADC_HI);
            end
            READ2: begin
                nre_2_d = 1'b0;
                adc_d   = (cnt_d >= ADC_LO) && (cnt_d <= ADC_HI);
            end
            default: begin
                erase_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            exp_len_q <= '0;
            erase_q   <= 1'b1;
            expose_q  <= 1'b0;
            nre_1_q   <= 1'b1;
            nre_2_q   <= 1'b1;
            adc_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exp_len_q <= exp_len_d;
            erase_q   <= erase_d;
            expose_q  <= expose_d;
            nre_1_q   <= nre_1_d;
            nre_2_q   <= nre_2_d;
            adc_q     <= adc_d;
            busy_q    <= busy_d;
        end
    end

    assign erase  = erase_q;
    assign expose = expose_q;
    assign nre_1  = nre_1_q;
    assign nre_2  = nre_2_q;
    assign adc    = adc_q;
    assign busy   = busy_q;

`ifdef CAM_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Count only captures that finish readout; an aborted capture is cleared by reset.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if ((state_q == READ2) && (state_d == IDLE))
            frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Completed-frame counter register.
    always_ff @(posedge clk) begin
        if (reset)
            frame_cnt_q <= 16'd0;
        else
            frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_cam_seq_ctrl.sv
// Testbench for cam_seq_ctrl: directed scenarios followed by random button traffic,
// all compared cycle by cycle against a timeline model of one capture.
module tb_cam_seq_ctrl;

    localparam int EXP_MIN     = 2;
    localparam int EXP_MAX     = 30;
    localparam int EXP_DEFAULT = 2;
    localparam int TICK_DIV    = 1;
    localparam int ADC_CYC     = 2;
    localparam int EXP_W       = 5;
    localparam int RD          = ADC_CYC + 2;

    logic             clk;
    logic             reset;
    logic             init;
    logic             expInc;
    logic             expDec;
    logic [EXP_W-1:0] expTime;
    logic             erase;
    logic             expose;
    logic             nre1;
    logic             nre2;
    logic             adc;
    logic             busy;
`ifdef CAM_FRAME_CNT_EN
    logic [15:0]      frameCnt;
`endif

    int testsRun;
    int testsFailed;

    // Reference model: the exposure setting, the position inside the current
    // capture (0 = idle, 1.. = cycles since init was taken), and frames done.
    int expModel;
    int phase;
    int capLen;
    int frameModel;

    cam_seq_ctrl #(
        .EXP_MIN     (EXP_MIN),
        .EXP_MAX     (EXP_MAX),
        .EXP_DEFAULT (EXP_DEFAULT),
        .TICK_DIV    (TICK_DIV),
        .ADC_CYC     (ADC_CYC),
        .EXP_W       (EXP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .exp_inc   (expInc),
        .exp_dec   (expDec),
        .exp_time  (expTime),
        .erase     (erase),
        .expose    (expose),
        .nre_1     (nre1),
        .nre_2     (nre2),
        .adc       (adc),
        .busy      (busy)
`ifdef CAM_FRAME_CNT_EN
        ,
        .frame_cnt (frameCnt)
`endif
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Compare every DUT output against what the timeline says for the current phase.
    task automatic checkAll();
        bit inExp, inR1, inR2, adcExp;
        int j1, j2;
        inExp  = (phase >= 1) && (phase <= capLen);
        inR1   = (phase > capLen) && (phase <= capLen + RD);
        inR2   = (phase > capLen + RD) && (phase <= capLen + 2 * RD);
        j1     = phase - capLen;
        j2     = phase - capLen - RD;
        adcExp = (inR1 && j1 >= 2 && j1 <= RD - 1) || (inR2 && j2 >= 2 && j2 <= RD - 1);
        checkOutput("exp_time", int'(expTime), expModel);
        checkOutput("erase",    int'(erase),   int'(phase == 0));
        checkOutput("busy",     int'(busy),    int'(phase != 0));
        checkOutput("expose",   int'(expose),  int'(inExp));
        checkOutput("nre_1",    int'(nre1),    int'(!inR1));
        checkOutput("nre_2",    int'(nre2),    int'(!inR2));
        checkOutput("adc",      int'(adc),     int'(adcExp));
        checkOutput("nre_both_low", int'(nre1 | nre2), 1);
`ifdef CAM_FRAME_CNT_EN
        checkOutput("frame_cnt", int'(frameCnt), frameModel);
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the clock edge, then check.
    task automatic applyStimulus(input bit i, input bit inc, input bit dec, input bit rst);
        init   = i;
        expInc = inc;
        expDec = dec;
        reset  = rst;
        @(posedge clk);
        if (rst) begin
            phase      = 0;
            expModel   = EXP_DEFAULT;
            frameModel = 0;
        end else if (phase == 0) begin
            if (i) begin
                phase  = 1;
                capLen = expModel * TICK_DIV;
            end else if (inc && !dec) begin
                expModel = (expModel + 1 > EXP_MAX) ? EXP_MAX : expModel + 1;
            end else if (dec && !inc) begin
                expModel = (expModel - 1 < EXP_MIN) ? EXP_MIN : expModel - 1;
            end
        end else begin
            phase++;
            if (phase > capLen + 2 * RD) begin
                phase      = 0;
                frameModel = (frameModel + 1) % 65536;
            end
        end
        #1;
        checkAll();
    endtask

    // Directed scenarios, then a long stretch of random stimulus.
    initial begin
        int eraseAt, exposeCnt, adcCnt, nre1Cnt, nre2Cnt;
        testsRun    = 0;
        testsFailed = 0;
        expModel    = EXP_DEFAULT;
        phase       = 0;
        capLen      = 0;
        frameModel  = 0;
        init        = 1'b0;
        expInc      = 1'b0;
        expDec      = 1'b0;
        reset       = 1'b1;

        // Reset values.
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("reset_exp_time", int'(expTime), 2);
        checkOutput("reset_erase", int'(erase), 1);
        checkOutput("reset_busy", int'(busy), 0);

        // Saturation at both limits.
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 0);
        checkOutput("sat_min", int'(expTime), 2);
        for (int k = 0; k < 40; k++) applyStimulus(0, 1, 0, 0);
        checkOutput("sat_max", int'(expTime), 30);
        for (int k = 0; k < 25; k++) applyStimulus(0, 0, 1, 0);
        checkOutput("set_to_5", int'(expTime), 5);

        // One capture with exposure 5: measure the waveform from the init sample.
        applyStimulus(1, 0, 0, 0);
        eraseAt   = -1;
        exposeCnt = int'(expose);
        adcCnt    = 0;
        nre1Cnt   = 0;
        nre2Cnt   = 0;
        for (int k = 2; k <= 20; k++) begin
            applyStimulus(0, 0, 0, 0);
            if (eraseAt < 0) begin
                if (erase) eraseAt = k;
                exposeCnt += int'(expose);
                adcCnt    += int'(adc);
                nre1Cnt   += int'(!nre1);
                nre2Cnt   += int'(!nre2);
            end
        end
        checkOutput("cap_erase_cycle", eraseAt, 14);
        checkOutput("cap_expose_len", exposeCnt, 5);
        checkOutput("cap_nre1_len", nre1Cnt, 4);
        checkOutput("cap_nre2_len", nre2Cnt, 4);
        checkOutput("cap_adc_len", adcCnt, 4);

        // inc and dec together hold; inc during exposure is ignored.
        applyStimulus(0, 1, 1, 0);
        checkOutput("inc_dec_hold", int'(expTime), 5);
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0);
        for (int k = 0; k < 14; k++) applyStimulus(0, 0, 0, 0);
        checkOutput("inc_in_expose", int'(expTime), 5);

        // Reset during the second exposure cycle aborts the capture.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_erase", int'(erase), 1);
        checkOutput("abort_exp_time", int'(expTime), 2);

        // Three full captures with init held high, relying on auto re-trigger.
        for (int k = 0; k < 3 * (2 + 2 * RD + 1); k++) applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 12; k++) applyStimulus(0, 0, 0, 0);
`ifdef CAM_FRAME_CNT_EN
        checkOutput("frame_cnt_3", int'(frameCnt), 3);
`endif
        checkOutput("after_frames_idle", int'(busy), 0);

        // Random traffic: buttons, init requests and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom % 8) == 0, ($urandom % 3) == 0,
                          ($urandom % 3) == 0, ($urandom % 250) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
